// File: rtl/alu_result_writeback.sv
// ALU result writeback stage.
// Captures a 64-bit ALU result on a start pulse and drives it onto the
// 32-bit internal bus with a valid/ready handshake. Mul/div results go out
// as two beats (LO, then HI) and also update the architectural HI/LO
// registers. All other opcodes go out as a single Z beat.
module alu_result_writeback #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [4:0]  OP_MUL = 5'b01110,
  parameter logic [4:0]  OP_DIV = 5'b01111
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] zhi_in,
  input  logic [WIDTH-1:0] zlo_in,
  input  logic             bus_ready,
  output logic             bus_valid,
  output logic [WIDTH-1:0] bus_data,
  output logic [1:0]       bus_dest,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE_LO = 2'd1,
    DRIVE_HI = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] DEST_Z  = 2'b00;
  localparam logic [1:0] DEST_LO = 2'b01;
  localparam logic [1:0] DEST_HI = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] zhi_cap_q;
  logic [WIDTH-1:0] zlo_cap_q;
  logic [4:0]       opcode_q;

  logic cap_en;
  logic lo_we;
  logic hi_we;
  logic two_beat;

  // Only mul and div carry a meaningful HI word; anything else is a Z result.
  assign two_beat = (opcode_q == OP_MUL) || (opcode_q == OP_DIV);

  // Next-state and bus outputs; outputs are pure decodes of the registered
  // state and captured data, so they hold steady while a beat is stalled.
  always_comb begin
    state_d   = state_q;
    cap_en    = 1'b0;
    lo_we     = 1'b0;
    hi_we     = 1'b0;
    bus_valid = 1'b0;
    bus_data  = '0;
    bus_dest  = DEST_Z;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_en  = 1'b1;
          state_d = DRIVE_LO;
        end
      end
      DRIVE_LO: begin
        bus_valid = 1'b1;
        bus_data  = zlo_cap_q;
        bus_dest  = two_beat ? DEST_LO : DEST_Z;
        if (bus_ready) begin
          if (two_beat) begin
            lo_we   = 1'b1;
            state_d = DRIVE_HI;
          end else begin
            state_d = DONE;
          end
        end
      end
      DRIVE_HI: begin
        bus_valid = 1'b1;
        bus_data  = zhi_cap_q;
        bus_dest  = DEST_HI;
        if (bus_ready) begin
          hi_we   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, capture and architectural HI/LO registers; reset clears everything
  // so an abandoned sequence leaves no partial HI/LO update behind.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      zhi_cap_q <= '0;
      zlo_cap_q <= '0;
      opcode_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        zhi_cap_q <= zhi_in;
        zlo_cap_q <= zlo_in;
        opcode_q  <= opcode;
      end
      if (lo_we) lo_q <= zlo_cap_q;
      if (hi_we) hi_q <= zhi_cap_q;
    end
  end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Downstream stage of the ALU.
- Captures the ALU's 64-bit result (ZHI/ZLO) on a start pulse, holds it, then sequences it onto the 32-bit internal bus with a valid/ready handshake.
- Multiply and divide results go out as two beats: LO, then HI. Both halves are also retained in the architectural HI and LO registers.
- All other operations go out as a single Z beat to the general register file.

Parameters:
- WIDTH, 32, datapath word width.
- OP_MUL, 5'b01110, opcode that produces a two-word result.
- OP_DIV, 5'b01111, opcode that produces a two-word result (HI = remainder, LO = quotient).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset.
- start  input  1  one-cycle capture request; sampled only in IDLE.
- opcode  input  5  ALU opcode accompanying the result, sampled with start.
- zhi_in  input  WIDTH  ALU high result word.
- zlo_in  input  WIDTH  ALU low result word.
- bus_ready  input  1  bus accepts the current beat.
- bus_valid  output  1  bus_data/bus_dest valid.
- bus_data  output  WIDTH  word being driven.
- bus_dest  output  2  00 = Z/general reg, 01 = LO, 10 = HI, 11 never driven.
- hi_q  output  WIDTH  architectural HI register.
- lo_q  output  WIDTH  architectural LO register.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (clr = 0, asynchronous, any state):
  - state = IDLE.
  - bus_valid, busy, done = 0; bus_data = 0; bus_dest = 00.
  - hi_q = lo_q = 0; internal capture registers = 0.
  - Reset mid-sequence abandons the sequence; no partial HI/LO update survives.
- States: IDLE, DRIVE_LO, DRIVE_HI, DONE.
- IDLE:
  - On start = 1, capture zhi_in, zlo_in and opcode into registers, then go to DRIVE_LO.
  - Otherwise stay in IDLE.
- DRIVE_LO:
  - bus_valid = 1; bus_data = captured LO word.
  - bus_dest = 01 if the captured opcode is OP_MUL or OP_DIV, else 00.
  - On bus_ready = 1: if dest is 01, lo_q <= captured LO and go to DRIVE_HI; otherwise go to DONE.
  - On bus_ready = 0: hold with outputs stable; the state may stall indefinitely.
- DRIVE_HI:
  - bus_valid = 1; bus_data = captured HI word; bus_dest = 10.
  - On bus_ready = 1: hi_q <= captured HI, go to DONE.
- DONE:
  - done = 1 and bus_valid = 0 for exactly one cycle, then return to IDLE.
- Latency:
  - start at cycle N gives the first valid beat at N+1.
  - With bus_ready held high: single-beat op has done at N+2; two-beat op has done at N+3.
- Handshake rules:
  - A beat transfers on the rising edge where bus_valid and bus_ready are both 1.
  - bus_data and bus_dest must not change while bus_valid = 1 and bus_ready = 0.
- start outside IDLE (including the DONE cycle) is ignored; the captured data are unaffected.
- ALU inputs changing after capture have no effect on the sequence in progress.
- HI/LO update only on their own handshake beat. hi_q and lo_q hold their values across non-mul/div ops.
- Unknown or unlisted opcodes are treated as single-beat Z results.
- No arithmetic is performed; the block is width-preserving and results pass through unmodified.

Test Plan:
- Add: opcode 00011, zlo_in = 0x0000_0005, zhi_in = 0, start, bus_ready = 1 → one beat with data 0x5, dest 00; done at N+2; hi_q and lo_q remain 0.
- Multiply: opcode 01110, zhi_in = 0x0000_0001, zlo_in = 0xFFFF_FFFE, bus_ready = 1 → beat 0xFFFF_FFFE dest 01, then beat 0x1 dest 10; afterwards lo_q = 0xFFFF_FFFE, hi_q = 0x1; done at N+3.
- Stall: divide (01110 replaced by 01111) with zhi_in = 0x3, zlo_in = 0x7, bus_ready low for 4 cycles in DRIVE_LO → bus_data stays 0x7 with dest 01 and lo_q unchanged; releasing ready gives 0x3 dest 10 on the next beat.
- Ignored start: a second start with different data during DRIVE_HI and during DONE → the original beats complete unchanged; the block returns to IDLE with no extra sequence.
- Async reset: clr = 0 mid-DRIVE_HI of a multiply → all outputs 0 immediately (not at the clock edge), hi_q = 0; after release, a new start behaves normally.
- Back-to-back: start asserted on the cycle right after done falls → accepted; the new sequence starts cleanly and HI/LO from the prior op are retained across an intervening AND op (opcode 01001).
